rx_ber_checker: RTL

Receive-side symbol decimator, slicer and bit-error-rate checker placed directly downstream of the polyphase raised-cosine FIR. It consumes one filter output per `i_enable` strobe at 4 samples/symbol, picks one sampling phase, slices the sign into a bit, and aligns that bit to the transmitted reference bit stream with an automatic delay search. Once aligned, it counts bits and errors for BER readout.

---
 rtl/rx_ber_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rx_ber_checker.sv
// Symbol decimator, sign slicer and BER checker for the raised-cosine receive path.
// Picks one of four sampling phases, aligns the sliced bit to the reference by delay search, then counts errors.
module rx_ber_checker #(
    parameter int NB_INPUT = 8,
    parameter int NB_DLY   = 4,
    parameter int NB_CNT   = 32,
    parameter int WINDOW   = 128,
    parameter int ERR_THR  = 4
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NB_INPUT-1:0] i_data,
    input  logic [1:0]          i_phase,
    input  logic                i_ref_bit,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_locked,
    output logic [NB_DLY-1:0]   o_delay,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count
);

    localparam int DLY_LEN = (1 << NB_DLY) - 1;
    localparam int NB_WIN  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int NB_WERR = $clog2(WINDOW + 1);
    localparam logic [NB_WIN-1:0]  WIN_LAST = NB_WIN'(WINDOW - 1);
    localparam logic [NB_WERR-1:0] WERR_THR = NB_WERR'(ERR_THR);
    localparam logic signed [NB_INPUT-1:0] ZERO = '0;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_cnt;
    logic [1:0]           phase_q;
    logic [DLY_LEN-1:0]   ref_sr;
    logic [DLY_LEN:0]     taps;
    logic [NB_WIN-1:0]    win_cnt;
    logic [NB_WERR-1:0]   win_err;
    logic [NB_WERR-1:0]   win_err_tot;
    logic                 sym_stb;
    logic                 dec;
    logic                 err;
    logic                 phase_chg;
    logic                 win_end;
    logic                 delay_inc;
    logic                 lock_clr;
    logic                 cnt_en;

    assign sym_stb   = i_enable && (phase_cnt == i_phase);
    assign dec       = ($signed(i_data) < ZERO);
    // Tap 0 is the live reference bit; tap k is the bit seen k strobes ago.
    assign taps      = {ref_sr, i_ref_bit};
    assign err       = dec ^ taps[o_delay];
    assign phase_chg = i_enable && (i_phase != phase_q);
    assign win_end   = sym_stb && !phase_chg && (win_cnt == WIN_LAST);
    assign win_err_tot = (&win_err) ? win_err : win_err + NB_WERR'(err);
    assign o_locked  = (state_q == LOCKED);

    always_comb begin
        state_d   = state_q;
        delay_inc = 1'b0;
        lock_clr  = 1'b0;
        cnt_en    = 1'b0;
        if (phase_chg) begin
            state_d = SEARCH;
        end else if (sym_stb) begin
            case (state_q)
                SEARCH: begin
                    if (win_end) begin
                        if (win_err_tot == '0) begin
                            state_d  = LOCKED;
                            lock_clr = 1'b1;
                        end else begin
                            delay_inc = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    cnt_en = 1'b1;
                    if (win_end && (win_err_tot > WERR_THR)) begin
                        state_d   = SEARCH;
                        delay_inc = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            phase_cnt   <= '0;
            phase_q     <= '0;
            ref_sr      <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_delay     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            o_bit_valid <= 1'b0;
            if (i_enable) begin
                phase_cnt <= phase_cnt + 2'd1;
                phase_q   <= i_phase;
            end
            if (sym_stb) begin
                o_bit       <= dec;
                o_bit_valid <= 1'b1;
                ref_sr      <= {ref_sr[DLY_LEN-2:0], i_ref_bit};
            end
            if (phase_chg || win_end) begin
                win_cnt <= '0;
                win_err <= '0;
            end else if (sym_stb) begin
                win_cnt <= win_cnt + NB_WIN'(1);
                win_err <= win_err_tot;
            end
            if (delay_inc) begin
                o_delay <= o_delay + NB_DLY'(1);
            end
            // A fresh lock clears the counters even though it lands on a strobe.
            if (lock_clr) begin
                o_bit_count <= '0;
                o_err_count <= '0;
            end else if (cnt_en) begin
                if (!(&o_bit_count)) begin
                    o_bit_count <= o_bit_count + NB_CNT'(1);
                end
                if (err && !(&o_err_count)) begin
                    o_err_count <= o_err_count + NB_CNT'(1);
                end
            end
        end
    end

endmodule
